// File: rtl/sprite_compositor_if.sv
// sprite_compositor_if: pixel timing, ROM and colour/collision signals of the sprite compositor
interface sprite_compositor_if #(
    parameter int NSPR = 4,
    parameter int SAW  = 10,
    parameter int BAW  = 16
);
    logic                 vidon;
    logic [9:0]           hc;
    logic [9:0]           vc;
    logic [NSPR*11-1:0]   spr_x;
    logic [NSPR*11-1:0]   spr_y;
    logic [NSPR-1:0]      spr_en;
    logic [NSPR-1:0]      spr_flip;
    logic [BAW-1:0]       bk_addr;
    logic [7:0]           bk_data;
    logic [NSPR*SAW-1:0]  spr_addr;
    logic [NSPR*8-1:0]    spr_data;
    logic [2:0]           red;
    logic [2:0]           green;
    logic [1:0]           blue;
    logic [NSPR-1:0]      hit_mask;
    logic                 hit;

    modport master (
        output vidon, hc, vc, spr_x, spr_y, spr_en, spr_flip, bk_data, spr_data,
        input  bk_addr, spr_addr, red, green, blue, hit_mask, hit
    );

    modport slave (
        input  vidon, hc, vc, spr_x, spr_y, spr_en, spr_flip, bk_data, spr_data,
        output bk_addr, spr_addr, red, green, blue, hit_mask, hit
    );
endinterface

// File: rtl/sprite_compositor.sv
// sprite_compositor: 3-stage background + prioritised sprite compositor with per-frame collision flags
module sprite_compositor #(
    parameter int         NSPR   = 4,
    parameter int         SPR_W  = 32,
    parameter int         SPR_H  = 32,
    parameter int         SAW    = 10,
    parameter int         BK_W   = 320,
    parameter int         BK_SH  = 1,
    parameter int         BAW    = 16,
    parameter logic [7:0] TRANSP = 8'hE3
) (
    input logic clk25,
    input logic rst_n,
    sprite_compositor_if.slave bus
);
    localparam int CW = $clog2(SPR_W);

    logic                fs;
    logic                live;
    logic [NSPR*11-1:0]  sx, sy, ex, ey;
    logic [NSPR-1:0]     sen, sfl, een, efl;
    logic [11:0]         h12, v12;
    logic [BAW-1:0]      ba;
    logic [NSPR-1:0]     ib, ib1, ib2;
    logic [NSPR*SAW-1:0] sa;
    logic                v1, v2;
    logic [NSPR-1:0]     opq, cc, coll;
    logic [7:0]          pix;

    assign fs  = bus.hc == 10'd0 && bus.vc == 10'd0;
    // the frame-start pixel already sees the values being captured for its frame
    assign ex  = fs ? bus.spr_x : sx;
    assign ey  = fs ? bus.spr_y : sy;
    assign een = fs ? bus.spr_en : sen;
    assign efl = fs ? bus.spr_flip : sfl;
    assign h12 = {2'b00, bus.hc};
    assign v12 = {2'b00, bus.vc};
    assign ba  = BAW'(32'(bus.vc >> BK_SH) * BK_W + 32'(bus.hc >> BK_SH));

    for (genvar g = 0; g < NSPR; g++) begin : ch
        logic [11:0]       x, y;
        logic [CW-1:0]     cx;
        logic [SAW-CW-1:0] ry;
        assign x  = {1'b0, ex[11*g +: 11]};
        assign y  = {1'b0, ey[11*g +: 11]};
        assign cx = CW'(h12 - x);
        assign ry = (SAW-CW)'(v12 - y);
        assign ib[g] = een[g] && h12 >= x && h12 < x + 12'(SPR_W) && v12 >= y && v12 < y + 12'(SPR_H);
        assign sa[SAW*g +: SAW] = ib[g] ? {ry, efl[g] ? ~cx : cx} : '0;
    end

    // stage 3: lowest-index opaque sprite wins over background; flag multi-sprite overlap
    always_comb begin
        pix = bus.bk_data;
        opq = '0;
        for (int i = NSPR - 1; i >= 0; i--) begin
            opq[i] = ib2[i] && bus.spr_data[8*i +: 8] != TRANSP;
            pix = opq[i] ? bus.spr_data[8*i +: 8] : pix;
        end
        cc = (v2 && (opq & (opq - NSPR'(1))) != '0) ? opq : '0;
    end

    // shadow capture, address/flag pipeline, output pixel and collision bookkeeping
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            sx <= '0;
            sy <= '0;
            sen <= '0;
            sfl <= '0;
            live <= 1'b0;
            bus.bk_addr <= '0;
            bus.spr_addr <= '0;
            ib1 <= '0;
            ib2 <= '0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            {bus.red, bus.green, bus.blue} <= 8'h00;
            coll <= '0;
            bus.hit_mask <= '0;
            bus.hit <= 1'b0;
        end else begin
            sx <= ex;
            sy <= ey;
            sen <= een;
            sfl <= efl;
            live <= live || fs;
            bus.bk_addr <= ba;
            bus.spr_addr <= sa;
            ib1 <= ib;
            v1 <= bus.vidon && (live || fs);
            ib2 <= ib1;
            v2 <= v1;
            {bus.red, bus.green, bus.blue} <= v2 ? pix : 8'h00;
            coll <= fs ? '0 : coll | cc;
            bus.hit_mask <= fs ? coll | cc : bus.hit_mask;
            bus.hit <= fs ? |(coll | cc) : bus.hit;
        end
    end
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed and randomized pixel streams checked against a frame-level reference model
module tb_sprite_compositor;
    localparam int         NSPR   = 4;
    localparam int         SPR_W  = 32;
    localparam int         SPR_H  = 32;
    localparam int         SAW    = 10;
    localparam int         BK_W   = 320;
    localparam int         BAW    = 16;
    localparam logic [7:0] TRANSP = 8'hE3;

    typedef struct {
        logic [7:0] e;
        string      tag;
    } exp_t;

    logic clk25 = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] mem [NSPR][SPR_W*SPR_H];
    int m_x [NSPR];
    int m_y [NSPR];
    bit m_en [NSPR];
    bit m_fl [NSPR];
    bit live;
    logic [NSPR-1:0] acc, exp_mask;
    exp_t q [$];
    int n_chk = 0;
    int n_pass = 0;

    sprite_compositor_if #(.NSPR(NSPR), .SAW(SAW), .BAW(BAW)) bus ();

    sprite_compositor #(
        .NSPR(NSPR), .SPR_W(SPR_W), .SPR_H(SPR_H), .SAW(SAW),
        .BK_W(BK_W), .BK_SH(1), .BAW(BAW), .TRANSP(TRANSP)
    ) dut (
        .clk25(clk25),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #20 clk25 = ~clk25;

    // registered-output ROMs: background holds its own low address byte
    always_ff @(posedge clk25) begin
        bus.bk_data <= bus.bk_addr[7:0];
        for (int i = 0; i < NSPR; i++) bus.spr_data[8*i +: 8] <= mem[i][bus.spr_addr[SAW*i +: SAW]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] bg(int h, int v);
        return 8'((((v / 2) * BK_W + h / 2) % (1 << BAW)));
    endfunction

    function automatic logic [7:0] model(int h, int v, bit vid);
        logic [7:0] px, d;
        logic [NSPR-1:0] o;
        int c;
        px = bg(h, v);
        o = '0;
        for (int i = 0; i < NSPR; i++) begin
            if (m_en[i] && h >= m_x[i] && h < m_x[i] + SPR_W && v >= m_y[i] && v < m_y[i] + SPR_H) begin
                c = m_fl[i] ? SPR_W - 1 - (h - m_x[i]) : h - m_x[i];
                d = mem[i][(v - m_y[i]) * SPR_W + c];
                if (d != TRANSP) begin
                    if (o == '0) px = d;
                    o[i] = 1'b1;
                end
            end
        end
        if (vid && live && $countones(o) >= 2) acc |= o;
        return (vid && live) ? px : 8'h00;
    endfunction

    task automatic step(input int h, input int v, input bit vid, input int k = -1, input string tag = "pix");
        exp_t e;
        @(negedge clk25);
        check("hit_mask", 32'(bus.hit_mask), 32'(exp_mask));
        check("hit", 32'(bus.hit), 32'(|exp_mask));
        if (q.size() == 3) begin
            e = q.pop_front();
            check(e.tag, 32'({bus.red, bus.green, bus.blue}), 32'(e.e));
        end
        bus.hc = 10'(h);
        bus.vc = 10'(v);
        bus.vidon = vid;
        if (h == 0 && v == 0) begin
            for (int i = 0; i < NSPR; i++) begin
                m_x[i] = int'(bus.spr_x[11*i +: 11]);
                m_y[i] = int'(bus.spr_y[11*i +: 11]);
                m_en[i] = bus.spr_en[i];
                m_fl[i] = bus.spr_flip[i];
            end
            live = 1'b1;
            exp_mask = acc;
            acc = '0;
        end
        e.e = model(h, v, vid);
        if (k >= 0) e.e = 8'(k);
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic frame_begin();
        step(0, 0, 1'b1);
    endtask

    task automatic frame_end();
        repeat (4) step(700, 500, 1'b0);
    endtask

    task automatic set_spr(input int i, input int x, input int y, input bit en, input bit fl);
        bus.spr_x[11*i +: 11] = 11'(x);
        bus.spr_y[11*i +: 11] = 11'(y);
        bus.spr_en[i] = en;
        bus.spr_flip[i] = fl;
    endtask

    task automatic fill_addr(input int i);
        for (int a = 0; a < SPR_W*SPR_H; a++) mem[i][a] = 8'(a);
    endtask

    task automatic fill_const(input int i, input logic [7:0] k);
        for (int a = 0; a < SPR_W*SPR_H; a++) mem[i][a] = k;
    endtask

    task automatic rand_cfg();
        for (int i = 0; i < NSPR; i++) begin
            set_spr(i, ($urandom_range(7) == 0) ? 2000 + int'($urandom_range(47)) :
                       ($urandom_range(7) == 0) ? 610 + int'($urandom_range(29)) : 80 + int'($urandom_range(120)),
                    ($urandom_range(7) == 0) ? 460 + int'($urandom_range(19)) : 40 + int'($urandom_range(120)),
                    $urandom_range(4) != 0, 1'($urandom_range(1)));
            for (int a = 0; a < SPR_W*SPR_H; a++) mem[i][a] = ($urandom_range(3) == 0) ? TRANSP : 8'($urandom);
        end
    endtask

    task automatic rand_frame(input int npix);
        int h, v, c;
        frame_begin();
        repeat (npix) begin
            if ($urandom_range(3) != 0) begin
                c = int'($urandom_range(NSPR - 1));
                h = m_x[c] - 4 + int'($urandom_range(39));
                v = m_y[c] - 4 + int'($urandom_range(39));
            end else begin
                h = int'($urandom_range(799));
                v = int'($urandom_range(524));
            end
            if (h < 0 || h > 799) h = int'($urandom_range(639));
            if (v < 0 || v > 524) v = int'($urandom_range(479));
            if (h == 0 && v == 0) h = 1;
            step(h, v, h < 640 && v < 480);
            if ($urandom_range(49) == 0)
                set_spr(int'($urandom_range(NSPR - 1)), 80 + int'($urandom_range(120)), 40 + int'($urandom_range(120)),
                        1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        frame_end();
    endtask

    initial begin
        bus.hc = 10'd700;
        bus.vc = 10'd500;
        bus.vidon = 1'b0;
        bus.spr_x = '0;
        bus.spr_y = '0;
        bus.spr_en = '0;
        bus.spr_flip = '0;
        live = 1'b0;
        acc = '0;
        exp_mask = '0;
        for (int i = 0; i < NSPR; i++) begin
            fill_const(i, 8'h00);
            m_x[i] = 0;
            m_y[i] = 0;
            m_en[i] = 1'b0;
            m_fl[i] = 1'b0;
        end
        #1;
        check("rst_rgb", 32'({bus.red, bus.green, bus.blue}), 0);
        check("rst_hit_mask", 32'(bus.hit_mask), 0);
        check("rst_hit", 32'(bus.hit), 0);
        check("rst_bk_addr", 32'(bus.bk_addr), 0);
        check("rst_spr_addr", 32'(bus.spr_addr), 0);
        repeat (2) @(negedge clk25);
        rst_n = 1'b1;

        // background only
        frame_begin();
        step(2, 0, 1'b1, 8'h01, "bg_2_0");
        step(639, 479, 1'b1, 8'hFF, "bg_639_479");
        repeat (40) step(1 + int'($urandom_range(638)), int'($urandom_range(479)), 1'b1);
        frame_end();

        // single sprite, plain then mirrored
        fill_addr(0);
        set_spr(0, 100, 50, 1'b1, 1'b0);
        frame_begin();
        step(105, 52, 1'b1, 8'h45, "spr0");
        step(99, 50, 1'b1, 8'h71, "left_edge");
        step(132, 50, 1'b1, 8'h82, "right_edge");
        step(131, 81, 1'b1);
        step(131, 82, 1'b1);
        frame_end();
        set_spr(0, 100, 50, 1'b1, 1'b1);
        frame_begin();
        step(105, 52, 1'b1, 8'h5A, "flip");
        step(100, 50, 1'b1);
        frame_end();

        // overlap: priority and collision reporting
        set_spr(0, 200, 200, 1'b1, 1'b0);
        set_spr(1, 200, 200, 1'b1, 1'b0);
        fill_const(1, 8'h1C);
        frame_begin();
        step(205, 201, 1'b1, 8'h25, "prio");
        step(210, 210, 1'b1);
        frame_end();
        set_spr(1, 400, 300, 1'b1, 1'b0);
        frame_begin();
        step(1, 0, 1'b1);
        check("hit_mask_coll", 32'(bus.hit_mask), 3);
        check("hit_coll", 32'(bus.hit), 1);
        step(205, 201, 1'b1, 8'h25, "spr0_alone");
        step(405, 301, 1'b1, 8'h1C, "spr1_alone");
        frame_end();

        // transparent sprite over opaque one
        set_spr(0, 200, 200, 1'b0, 1'b0);
        set_spr(1, 300, 100, 1'b1, 1'b0);
        set_spr(2, 300, 100, 1'b1, 1'b0);
        fill_const(1, TRANSP);
        fill_const(2, 8'h3C);
        frame_begin();
        step(1, 0, 1'b1);
        check("hit_mask_sep", 32'(bus.hit_mask), 0);
        step(310, 110, 1'b1, 8'h3C, "transp");
        step(320, 120, 1'b1);
        frame_end();

        // mid-frame move takes effect next frame
        set_spr(1, 300, 100, 1'b0, 1'b0);
        set_spr(2, 300, 100, 1'b0, 1'b0);
        set_spr(0, 100, 250, 1'b1, 1'b0);
        frame_begin();
        step(1, 0, 1'b1);
        check("hit_mask_transp", 32'(bus.hit_mask), 0);
        step(50, 239, 1'b1);
        set_spr(0, 300, 250, 1'b1, 1'b0);
        step(60, 240, 1'b1);
        step(105, 260, 1'b1, 8'h45, "old_pos");
        step(305, 260, 1'b1, 8'h18, "new_pos_early");
        frame_end();
        frame_begin();
        step(305, 260, 1'b1, 8'h45, "new_pos");
        step(105, 260, 1'b1, 8'hB4, "old_pos_bg");
        frame_end();

        // far-right sprite must not wrap onto column 0
        set_spr(0, 2040, 0, 1'b1, 1'b0);
        frame_begin();
        step(3, 2, 1'b1, 8'h41, "wrap");
        for (int h = 1; h < 12; h++) step(h, 1, 1'b1);
        frame_end();

        repeat (8) begin
            rand_cfg();
            rand_frame(250);
        end

        // reset in mid-frame after a collision frame
        for (int i = 0; i < NSPR; i++) set_spr(i, 0, 0, 1'b0, 1'b0);
        set_spr(0, 100, 100, 1'b1, 1'b0);
        set_spr(1, 100, 100, 1'b1, 1'b0);
        fill_const(0, 8'h11);
        fill_const(1, 8'h22);
        frame_begin();
        step(105, 105, 1'b1, 8'h11, "coll_px");
        frame_end();
        frame_begin();
        step(1, 0, 1'b1);
        check("hit_mask_pre_rst", 32'(bus.hit_mask), 3);
        step(110, 299, 1'b1);
        step(110, 300, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_rgb", 32'({bus.red, bus.green, bus.blue}), 0);
        check("midrst_hit_mask", 32'(bus.hit_mask), 0);
        check("midrst_hit", 32'(bus.hit), 0);
        q.delete();
        live = 1'b0;
        acc = '0;
        exp_mask = '0;
        for (int i = 0; i < NSPR; i++) m_en[i] = 1'b0;
        step(111, 300, 1'b1);
        step(112, 300, 1'b1);
        rst_n = 1'b1;
        for (int h = 113; h < 130; h++) step(h, 300, 1'b1);
        step(105, 105, 1'b1, 8'h00, "post_rst_black");
        step(200, 310, 1'b1, 8'h00, "post_rst_black_bg");
        frame_end();
        frame_begin();
        step(105, 105, 1'b1, 8'h11, "after_rearm");
        step(200, 310, 1'b1);
        frame_end();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised VGA pixel compositor for the game display path.
- Merges one scaled background ROM and NSPR sprite ROMs, each with a registered output, into 8-bit RRRGGGBB pixels for the 640x480 timing generator.
- Adds features the current fixed mario/mushroom path lacks:
  - N sprite channels with fixed priority
  - per-sprite horizontal flip
  - frame-synchronous coordinate shadowing
  - per-frame sprite collision detection

Parameters:
- NSPR, 4, number of sprite channels; index 0 has the highest priority.
- SPR_W, 32, sprite width in pixels; must be a power of 2.
- SPR_H, 32, sprite height in pixels.
- SAW, 10, sprite ROM address width; log2(SPR_W*SPR_H).
- BK_W, 320, background ROM row width in pixels.
- BK_SH, 1, background scale shift; 1 means each ROM pixel covers 2x2 screen pixels.
- BAW, 16, background ROM address width.
- TRANSP, 8'hE3, sprite colour treated as transparent.

Ports:
- clk25  in  1  25 MHz pixel clock
- rst_n  in  1  asynchronous active-low reset
- vidon  in  1  visible-area flag from vga_640x480
- hc  in  10  horizontal counter; visible range 0..639
- vc  in  10  vertical counter; visible range 0..479
- spr_x  in  NSPR*11  sprite top-left column; channel i at bits [11i+10:11i]
- spr_y  in  NSPR*11  sprite top-left row, packed the same way
- spr_en  in  NSPR  sprite enable
- spr_flip  in  NSPR  horizontal mirror
- bk_addr  out  BAW  background ROM address
- bk_data  in  8  background ROM data; valid one clk25 after the address
- spr_addr  out  NSPR*SAW  sprite ROM addresses
- spr_data  in  NSPR*8  sprite ROM data; valid one clk25 after the address
- red  out  3  colour output
- green  out  3  colour output
- blue  out  2  colour output
- hit_mask  out  NSPR  sprites involved in any collision during the previous frame
- hit  out  1  OR of hit_mask

Behaviour:
- Reset (asynchronous, rst_n=0) clears every register: red, green, blue, hit_mask, hit, bk_addr, spr_addr, all shadow registers, and all pipeline flags.
- Shadow registers:
  - spr_x, spr_y, spr_en and spr_flip are captured into shadow registers only on the frame-start cycle (hc==0 && vc==0).
  - All compositing uses the shadow values, so mid-frame input changes take effect from the next frame; there is no tearing.
- Stage 1 (addresses registered):
  - bk_addr = (vc>>BK_SH)*BK_W + (hc>>BK_SH), truncated to BAW bits.
  - For each channel i: col = hc - x_i, row = vc - y_i, computed 12 bits wide.
  - inbox_i = en_i && hc>=x_i && hc<x_i+SPR_W && vc>=y_i && vc<y_i+SPR_H.
  - Comparisons are 12-bit, so a sprite at x=2040 never wraps onto column 0.
  - spr_addr_i = row*SPR_W + (flip_i ? SPR_W-1-col : col) when inbox_i, otherwise 0.
  - inbox_i and vidon are registered alongside the addresses.
- Stage 2: ROM data arrives; inbox and vidon flags are delayed one more cycle to stay aligned with the data.
- Stage 3 (output register):
  - opaque_i = inbox_i && spr_data_i != TRANSP.
  - Pixel = spr_data of the lowest-index opaque channel; otherwise bk_data.
  - If the aligned vidon is 0, the pixel is 8'h00.
  - {red,green,blue} = pixel.
- Latency: exactly 3 clk25 cycles from (hc,vc) to RGB. The vga_640x480 sync outputs must be delayed 3 cycles by the instantiating level.
- Collision detection:
  - On any stage-3 cycle with aligned vidon=1 and two or more channels opaque, each opaque channel's bit is ORed into an internal sticky register coll.
  - At frame start: hit_mask <= coll (including any collision in the same cycle), then coll clears. hit_mask therefore holds for one full frame.
  - Collisions outside the visible area are ignored.
- Disabled sprites (shadow en=0) never set inbox, never draw, and never collide.
- A sprite partially off the right or bottom edge is clipped naturally; pixels beyond 639/479 are blanked by vidon.
- Reset mid-frame: the outputs are black until the first frame start after release; before that frame start all sprites are disabled, because shadow en=0.

Test Plan:
- Reset, then one frame with all spr_en=0 and background ROM model data = address[7:0] -> pixel at (hc=2,vc=0) output 3 cycles later = 8'h01 (bk_addr 1); the (639,479) pixel = low byte of 239*320+319 = 76799 -> 8'hFF; hit=0.
- Sprite 0 at (100,50), enabled, ROM model data = addr[7:0] -> screen (105,52) shows 8'h45 (addr 69); with spr_flip[0]=1 it shows 8'h5A (addr 90). Pixels at (99,50) and (132,50) show background.
- Sprites 0 and 1 at the same (200,200), both opaque -> sprite 0 colour wins; after the next frame start hit_mask=4'b0011 and hit=1. The following frame with the sprites separated -> hit_mask returns to 0.
- Sprite 1 pixel = TRANSP overlapping opaque sprite 2 -> sprite 2 colour shown; no collision bit set.
- Change spr_x[0] from 100 to 300 at vc=240 -> rest of current frame still draws at 100; next frame draws at 300.
- Sprite at x=2040 (wrap test) -> nothing drawn at column 0. Assert rst_n=0 at vc=300 -> RGB=0 immediately, hit_mask=0; after release, output stays black until the next frame start.
